// File: rtl/gradient_ramp_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gradient_ramp_sequencer
// Description : Slew-limited gradient amplitude sequencer. Walks the output
//               amplitude from its current value toward a signed target in
//               steps of at most cfg_step, one step per divided sample period,
//               and streams each sample over a valid/ready handshake.
//               Optional target saturation is enabled by defining the macro
//               GRAD_CLAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gradient_ramp_sequencer #(
    parameter int DATA_W    = 16,
    parameter int DIV_W     = 16,
    parameter int AMP_LIMIT = 30000
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic signed [DATA_W-1:0] cfg_target,
    input  logic        [DATA_W-1:0] cfg_step,
    input  logic        [DIV_W-1:0]  cfg_div,
    input  logic                     cfg_start,
    input  logic                     cfg_abort,
    output logic signed [DATA_W-1:0] m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic signed [DATA_W-1:0] cur_amp,
    output logic                     busy,
    output logic                     done,
    output logic                     clamp_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

`ifdef GRAD_CLAMP_EN
    localparam bit c_clamp_en = 1'b1;
`else
    localparam bit c_clamp_en = 1'b0;
`endif
    localparam logic signed [DATA_W-1:0] c_lim_pos = DATA_W'(AMP_LIMIT);
    localparam logic signed [DATA_W-1:0] c_lim_neg = -c_lim_pos;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic signed [DATA_W-1:0]   r_tgt;
    logic        [DATA_W-1:0]   r_step;
    logic        [DIV_W-1:0]    r_div;
    logic        [DIV_W-1:0]    r_cnt;
    logic                       r_tick_pend;
    logic signed [DATA_W-1:0]   r_cur;
    logic signed [DATA_W-1:0]   r_data;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_clamp;
    logic                       r_abort;

    logic                       w_start_acc;
    logic                       w_handshake;
    logic                       w_slot_free;
    logic                       w_tick;
    logic                       w_step_fire;
    logic                       w_done_nxt;
    logic signed [DATA_W:0]     w_diff;
    logic signed [DATA_W:0]     w_neg_diff;
    logic        [DATA_W:0]     w_abs_diff;
    logic                       w_reach;
    logic signed [DATA_W-1:0]   w_next;
    logic signed [DATA_W-1:0]   w_tgt_sat;
    logic                       w_clamp;
    logic                       w_over;
    logic                       w_under;

    // A start is taken only from IDLE and loses to a simultaneous abort
    assign w_start_acc = (r_state == ST_IDLE) && cfg_start && !cfg_abort;
    assign w_handshake = r_valid && m_tready;
    assign w_slot_free = !r_valid || m_tready;
    assign w_tick      = (r_state == ST_RAMP) && (r_cnt == r_div);
    // A step needs a tick (fresh or pending), a free output slot, and no abort
    assign w_step_fire = (r_state == ST_RAMP) && !cfg_abort &&
                         (w_tick || r_tick_pend) && w_slot_free;

    // Difference in one extra bit so that full-scale swings cannot wrap
    assign w_diff     = {r_tgt[DATA_W-1], r_tgt} - {r_cur[DATA_W-1], r_cur};
    assign w_neg_diff = -w_diff;
    assign w_abs_diff = w_diff[DATA_W] ? $unsigned(w_neg_diff) : $unsigned(w_diff);
    assign w_reach    = (r_step == '0) || (w_abs_diff <= {1'b0, r_step});
    assign w_next     = w_reach        ? r_tgt :
                        w_diff[DATA_W] ? (r_cur - r_step) : (r_cur + r_step);

    // Target saturation at start accept; collapses to pass-through when disabled
    assign w_over    = cfg_target > c_lim_pos;
    assign w_under   = cfg_target < c_lim_neg;
    assign w_clamp   = c_clamp_en && (w_over || w_under);
    assign w_tgt_sat = (c_clamp_en && w_over)  ? c_lim_pos :
                       (c_clamp_en && w_under) ? c_lim_neg : cfg_target;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and done-pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (cfg_abort) begin
                    // A stalled sample must still be delivered before idling
                    w_state_nxt = (r_valid && !m_tready) ? ST_DRAIN : ST_IDLE;
                end else if (w_step_fire && (w_next == r_tgt)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_handshake) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = !r_abort && !cfg_abort;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Configuration latch, divider, pending tick and output slot
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tgt       <= '0;
            r_step      <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_tick_pend <= 1'b0;
            r_cur       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clamp     <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);

            if (w_start_acc) begin
                r_tgt       <= w_tgt_sat;
                r_step      <= cfg_step;
                r_div       <= cfg_div;
                r_cnt       <= '0;
                r_tick_pend <= 1'b0;
                r_clamp     <= w_clamp;
                r_abort     <= 1'b0;
            end else if (r_state == ST_RAMP) begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                // Only one tick can be banked; extra ticks while blocked are dropped
                if (w_step_fire) begin
                    r_tick_pend <= 1'b0;
                end else if (w_tick) begin
                    r_tick_pend <= 1'b1;
                end
            end

            if ((r_state != ST_IDLE) && cfg_abort) begin
                r_abort <= 1'b1;
            end

            if (w_step_fire) begin
                r_data  <= w_next;
                r_cur   <= w_next;
                r_valid <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_tdata    = r_data;
    assign m_tvalid   = r_valid;
    assign cur_amp    = r_cur;
    assign busy       = r_busy;
    assign done       = r_done;
    assign clamp_flag = r_clamp;

endmodule
`default_nettype wire

// File: doc/gradient_ramp_sequencer.md
Name: gradient_ramp_sequencer

Overview:
- Sits directly downstream of the fpga_mri_gradient_control AXI4-Lite register block.
- Consumes its target-amplitude, slew-step, sample-divider, start and abort controls.
- Produces a slew-limited stream of signed gradient amplitude samples for the gradient DAC driver over a valid/ready handshake.
- Returns busy/done status to the register block. Software builds trapezoids by issuing successive starts (ramp-up, plateau via the divider, ramp-down).

Parameters:
- DATA_W, 16: sample and amplitude width, signed two's complement.
- DIV_W, 16: sample-rate divider width.
- AMP_LIMIT, 30000: magnitude limit applied to the target when GRAD_CLAMP_EN is defined; must be <= 2^(DATA_W-1)-1.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset. Synchronous, active-high.
- cfg_target  in  DATA_W  signed target amplitude.
- cfg_step  in  DATA_W  unsigned slew step per sample; 0 = jump directly to target.
- cfg_div  in  DIV_W  sample period in ACLK cycles minus 1.
- cfg_start  in  1  single-cycle start pulse.
- cfg_abort  in  1  single-cycle abort pulse.
- m_tdata  out  DATA_W  amplitude sample.
- m_tvalid  out  1  sample valid.
- m_tready  in  1  downstream accept.
- cur_amp  out  DATA_W  last amplitude issued (ramp origin for next start).
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse on normal completion.
- clamp_flag  out  1  target was clamped (sticky until next accepted start).

Behaviour:
- Reset: state IDLE; cur_amp, m_tdata, m_tvalid, busy, done, clamp_flag, divider counter and tick_pending all 0.
- States:
  - IDLE: cfg_start accepted. Latch target, step and div; clear counter and tick_pending; busy=1; go to RAMP.
  - RAMP: issue samples until the last issued sample equals the target.
  - DRAIN: wait for the final or in-flight sample to be accepted, then go to IDLE.
- Divider: in RAMP the counter increments each cycle and wraps at the latched div. Tick when counter==div.
  - First tick occurs div+1 cycles after the start-accept cycle. div=0 ticks every cycle.
- Step computation on an effective tick:
  - Difference is computed target-cur_amp in DATA_W+1 bits.
  - If |diff| <= step, or step==0: next = target.
  - Else: next = cur_amp ± step, moving toward target. No overshoot, no wrap.
  - next is registered into m_tdata and cur_amp; m_tvalid=1 the following cycle (1-cycle latency from tick).
- Backpressure:
  - An effective tick requires the output slot to be free: m_tvalid=0, or m_tvalid&&m_tready this cycle.
  - A tick arriving while the slot is held sets tick_pending. The step fires on the first cycle the slot frees.
  - At most one pending tick. Further ticks while pending are dropped; sample spacing stretches, no sample is lost.
  - m_tdata is stable while m_tvalid&&!m_tready. m_tvalid never drops without a handshake.
- Completion: when the issued sample equals target, go to DRAIN. On its handshake: done=1 for one cycle, busy=0, go to IDLE. cur_amp is retained.
- Already-at-target start (target==cur_amp): one sample equal to target is still issued, then normal completion.
- Abort:
  - In RAMP or DRAIN, cfg_abort stops new steps immediately.
  - Any valid sample is held until accepted, then the block returns to IDLE with busy=0 and no done pulse. cur_amp holds the last issued value.
  - Abort in IDLE is ignored.
- Simultaneous events:
  - cfg_start while busy: ignored.
  - cfg_start and cfg_abort in the same cycle in IDLE: start ignored.
  - Config inputs are sampled only at start accept.
- ARESET asserted mid-ramp: immediate return to reset values on the next edge, including m_tvalid=0.

Optional Feature:
- Macro: GRAD_CLAMP_EN.
- Defined: the latched target is saturated to [-AMP_LIMIT, +AMP_LIMIT] at start accept. clamp_flag is set if saturation occurred and cleared at the next accepted start.
- Undefined: the target is used unmodified and clamp_flag is tied to 0.

Test Plan:
- Reset check: assert ARESET 3 cycles mid-ramp -> next cycle m_tvalid=0, m_tdata=0, cur_amp=0, busy=0, done=0.
- Up-ramp: cur_amp 0, target 100, step 30, div 3, m_tready=1.
  - Samples 30, 60, 90, 100 spaced 4 cycles apart; first m_tvalid 5 cycles after start.
  - done pulses 1 cycle after the 100 handshake; busy then 0.
- Down-ramp with sign change: from cur_amp 100, target -50, step 60, div 0 -> samples 40, -20, -50 on consecutive accepts; cur_amp=-50.
- Backpressure: the up-ramp case with m_tready low for 10 cycles after the first sample.
  - m_tdata holds 30 throughout.
  - Remaining sequence is 60, 90, 100 with none skipped and no duplicates.
- Abort: cfg_abort asserted 1 cycle after the 60 sample handshake in the up-ramp -> no further samples, busy=0, no done pulse, cur_amp=60.
- Clamp: target 32000, step 0.
  - With GRAD_CLAMP_EN: single sample 30000, clamp_flag=1.
  - Without GRAD_CLAMP_EN: single sample 32000, clamp_flag=0.
